// File: rtl/spare_remap_table.sv
// spare_remap_table: physical-slot to logical-row remap table for one systolic
// dimension, with a fault mask, a registered allocation search and
// combinational lookup ports.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mask_load           pulse: capture fault_mask and re-initialise the table
//   fault_mask          bit i=1 means physical slot i is faulty
//   req_*               allocation request (valid/ready, mode, target, src)
//   rsp_*               one-cycle response pulse with slot and status
//   rd_addr/rd_data     packed combinational lookup ports
//   rd_alloc            allocated bit of each looked-up slot
//   loaded, alloc_count, full  table status
// Optional (macro REMAP_INVERSE_EN):
//   inv_addr/inv_slot/inv_hit  combinational reverse lookup
module spare_remap_table #(
  parameter int unsigned N_LINES      = 8,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned ADDR_WIDTH   = $clog2(N_LINES),
  parameter int unsigned CNT_WIDTH    = $clog2(N_LINES + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 mask_load,
  input  logic [N_LINES-1:0]                   fault_mask,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [1:0]                           req_mode,
  input  logic [ADDR_WIDTH-1:0]                req_target,
  input  logic [ADDR_WIDTH-1:0]                req_src,
  output logic                                 rsp_valid,
  output logic [ADDR_WIDTH-1:0]                rsp_slot,
  output logic [1:0]                           rsp_status,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]              rd_alloc,
  output logic                                 loaded,
  output logic [CNT_WIDTH-1:0]                 alloc_count,
  output logic                                 full
`ifdef REMAP_INVERSE_EN
  ,
  input  logic [ADDR_WIDTH-1:0]                inv_addr,
  output logic [ADDR_WIDTH-1:0]                inv_slot,
  output logic                                 inv_hit
`endif
);

  localparam logic [1:0] MODE_DIRECT  = 2'd0;
  localparam logic [1:0] MODE_AUTO    = 2'd1;
  localparam logic [1:0] MODE_HEALTHY = 2'd2;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_DEG  = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_COMMIT} state_t;

  state_t                  state_q, state_d;
  logic                    accept_c;
  logic                    reinit_c;
  logic                    commit_c;

  logic [1:0]              mode_q;
  logic [ADDR_WIDTH-1:0]   target_q;
  logic [ADDR_WIDTH-1:0]   src_q;

  logic [ADDR_WIDTH-1:0]   table_q [N_LINES];
  logic [N_LINES-1:0]      fault_q;
  logic [N_LINES-1:0]      alloc_q;

  logic [ADDR_WIDTH-1:0]   cand_slot;
  logic [1:0]              cand_status;
  logic                    h_found, f_found;
  logic [ADDR_WIDTH-1:0]   h_slot, f_slot;

  // Mask load is blocked outside IDLE; requests never accepted alongside it.
  assign req_ready = (state_q == S_IDLE) && loaded && !mask_load;
  assign reinit_c  = (state_q == S_IDLE) && mask_load;
  assign commit_c  = (state_q == S_COMMIT) && (rsp_status != ST_FAIL);

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept_c = 1'b1;
          state_d  = S_SEARCH;
        end
      end
      S_SEARCH: state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Candidate search; descending scan so the lowest free index wins.
  always_comb begin
    h_found     = 1'b0;
    f_found     = 1'b0;
    h_slot      = '0;
    f_slot      = '0;
    cand_slot   = '0;
    cand_status = ST_FAIL;
    for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        if (fault_q[i]) begin
          f_found = 1'b1;
          f_slot  = ADDR_WIDTH'(i);
        end else begin
          h_found = 1'b1;
          h_slot  = ADDR_WIDTH'(i);
        end
      end
    end
    case (mode_q)
      MODE_DIRECT: begin
        if ((32'(target_q) < N_LINES) && !alloc_q[target_q]) begin
          cand_slot   = target_q;
          cand_status = fault_q[target_q] ? ST_DEG : ST_OK;
        end
      end
      MODE_AUTO: begin
        if (h_found) begin
          cand_slot   = h_slot;
          cand_status = ST_OK;
        end else if (f_found) begin
          cand_slot   = f_slot;
          cand_status = ST_DEG;
        end
      end
      MODE_HEALTHY: begin
        if (h_found) begin
          cand_slot   = h_slot;
          cand_status = ST_OK;
        end
      end
      default: ;
    endcase
  end

  // State, request capture, response and table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      target_q    <= '0;
      src_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_slot    <= '0;
      rsp_status  <= ST_OK;
      loaded      <= 1'b0;
      fault_q     <= '0;
      alloc_q     <= '0;
      alloc_count <= '0;
      full        <= 1'b0;
      for (int unsigned i = 0; i < N_LINES; i++) table_q[i] <= ADDR_WIDTH'(i);
    end else begin
      state_q   <= state_d;
      rsp_valid <= (state_q == S_SEARCH);
      if (accept_c) begin
        mode_q   <= req_mode;
        target_q <= req_target;
        src_q    <= req_src;
      end
      if (state_q == S_SEARCH) begin
        rsp_slot   <= cand_slot;
        rsp_status <= cand_status;
      end
      if (commit_c) begin
        table_q[rsp_slot] <= src_q;
        alloc_q[rsp_slot] <= 1'b1;
        alloc_count       <= alloc_count + CNT_WIDTH'(1);
        full              <= (alloc_count + CNT_WIDTH'(1)) == CNT_WIDTH'(N_LINES);
      end
      if (reinit_c) begin
        fault_q     <= fault_mask;
        alloc_q     <= '0;
        alloc_count <= '0;
        full        <= 1'b0;
        loaded      <= 1'b1;
        for (int unsigned i = 0; i < N_LINES; i++) table_q[i] <= ADDR_WIDTH'(i);
      end
    end
  end

  // Lookup ports.
  always_comb begin
    rd_data  = '0;
    rd_alloc = '0;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      rd_data[p*ADDR_WIDTH +: ADDR_WIDTH] = table_q[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
      rd_alloc[p] = alloc_q[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

`ifdef REMAP_INVERSE_EN
  // Reverse lookup: lowest allocated slot holding inv_addr.
  always_comb begin
    inv_hit  = 1'b0;
    inv_slot = '0;
    for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
      if (alloc_q[i] && (table_q[i] == inv_addr)) begin
        inv_hit  = 1'b1;
        inv_slot = ADDR_WIDTH'(i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_spare_remap_table.sv
module tb_spare_remap_table;

  localparam int N  = 8;
  localparam int P  = 2;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mask_load = 1'b0;
  logic [N-1:0]  fault_mask = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_mode = '0;
  logic [AW-1:0] req_target = '0;
  logic [AW-1:0] req_src = '0;
  logic          rsp_valid;
  logic [AW-1:0] rsp_slot;
  logic [1:0]    rsp_status;
  logic [P*AW-1:0] rd_addr = '0;
  logic [P*AW-1:0] rd_data;
  logic [P-1:0]  rd_alloc;
  logic          loaded;
  logic [CW-1:0] alloc_count;
  logic          full;
`ifdef REMAP_INVERSE_EN
  logic [AW-1:0] inv_addr = '0;
  logic [AW-1:0] inv_slot;
  logic          inv_hit;
`endif

  spare_remap_table #(.N_LINES(N), .NUM_RD_PORTS(P)) dut (
    .clk(clk), .rst_n(rst_n), .mask_load(mask_load), .fault_mask(fault_mask),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_target(req_target), .req_src(req_src), .rsp_valid(rsp_valid),
    .rsp_slot(rsp_slot), .rsp_status(rsp_status), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_alloc(rd_alloc), .loaded(loaded),
    .alloc_count(alloc_count), .full(full)
`ifdef REMAP_INVERSE_EN
    , .inv_addr(inv_addr), .inv_slot(inv_slot), .inv_hit(inv_hit)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  int m_tab[N];
  bit m_alloc[N];
  bit m_fault[N];
  bit m_loaded;
  int m_lat;              // cycles since accept (0 = idle)
  int m_slot, m_status;   // last response
  int p_slot, p_status, p_src;

  function automatic void model_init(input logic [N-1:0] fm);
    for (int i = 0; i < N; i++) begin
      m_tab[i] = i; m_alloc[i] = 1'b0; m_fault[i] = fm[i];
    end
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_alloc[i]);
    return c;
  endfunction

  // Lowest free slot matching the health requirement, -1 if none.
  function automatic int first_free(input bit want_faulty);
    for (int i = 0; i < N; i++)
      if (!m_alloc[i] && (m_fault[i] == want_faulty)) return i;
    return -1;
  endfunction

  function automatic void model_search(input int mode, input int tgt,
                                       output int slot, output int st);
    int h, f;
    slot = 0; st = 2;
    h = first_free(1'b0);
    f = first_free(1'b1);
    if (mode == 0) begin
      if (!m_alloc[tgt]) begin slot = tgt; st = m_fault[tgt] ? 1 : 0; end
    end else if (mode == 1) begin
      if (h >= 0) begin slot = h; st = 0; end
      else if (f >= 0) begin slot = f; st = 1; end
    end else if (mode == 2) begin
      if (h >= 0) begin slot = h; st = 0; end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_init('0);
      m_loaded = 1'b0; m_lat = 0; m_slot = 0; m_status = 0;
      p_slot = 0; p_status = 0; p_src = 0;
    end else if (m_lat == 2) begin
      if (p_status != 2) begin m_tab[p_slot] = p_src; m_alloc[p_slot] = 1'b1; end
      m_lat = 0;
    end else if (m_lat == 1) begin
      m_lat = 2; m_slot = p_slot; m_status = p_status;
    end else if (mask_load) begin
      model_init(fault_mask);
      m_loaded = 1'b1;
    end else if (req_valid && m_loaded) begin
      model_search(int'(req_mode), int'(req_target), p_slot, p_status);
      p_src = int'(req_src);
      m_lat = 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      int a;
      chk("req_ready", int'(req_ready), int'(m_lat == 0 && m_loaded && !mask_load));
      chk("rsp_valid", int'(rsp_valid), int'(m_lat == 2));
      chk("rsp_slot", int'(rsp_slot), m_slot);
      chk("rsp_status", int'(rsp_status), m_status);
      chk("loaded", int'(loaded), int'(m_loaded));
      chk("alloc_count", int'(alloc_count), model_count());
      chk("full", int'(full), int'(model_count() == N));
      for (int p = 0; p < P; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        chk("rd_data", int'(rd_data[p*AW +: AW]), m_tab[a]);
        chk("rd_alloc", int'(rd_alloc[p]), int'(m_alloc[a]));
      end
`ifdef REMAP_INVERSE_EN
      begin
        int es; bit eh;
        es = 0; eh = 1'b0;
        for (int i = N - 1; i >= 0; i--)
          if (m_alloc[i] && m_tab[i] == int'(inv_addr)) begin eh = 1'b1; es = i; end
        chk("inv_hit", int'(inv_hit), int'(eh));
        chk("inv_slot", int'(inv_slot), es);
      end
`endif
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_req(input logic [1:0] mode, input int tgt, input int src,
                        output int slot, output int st);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_mode = mode; req_target = AW'(tgt); req_src = AW'(src);
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready_timeout", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rsp_pulse", int'(rsp_valid), 1);
    slot = int'(rsp_slot); st = int'(rsp_status);
    @(posedge clk); #1;
  endtask

  task automatic pulse_mask(input logic [N-1:0] fm);
    @(posedge clk); #1;
    mask_load = 1'b1; fault_mask = fm;
    @(posedge clk); #1;
    mask_load = 1'b0;
  endtask

  int s, st;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("lit_reset_loaded", int'(loaded), 0);
    chk("lit_reset_ready", int'(req_ready), 0);
    chk("lit_reset_count", int'(alloc_count), 0);

    // Load mask: slots 0 and 2 faulty.
    rd_addr = {3'd2, 3'd5};
    pulse_mask(8'b0000_0101);
    @(negedge clk);
    chk("lit_loaded", int'(loaded), 1);
    chk("lit_ready", int'(req_ready), 1);
    chk("lit_rd0_identity", int'(rd_data[2:0]), 5);
    chk("lit_rd1_identity", int'(rd_data[5:3]), 2);

    rd_addr = {3'd2, 3'd1};
    do_req(2'd1, 0, 3, s, st);
    chk("lit_auto_slot", s, 1);
    chk("lit_auto_status", st, 0);
    chk("lit_auto_rd", int'(rd_data[2:0]), 3);
    chk("lit_auto_count", int'(alloc_count), 1);
`ifdef REMAP_INVERSE_EN
    inv_addr = 3'd3; #1;
    chk("lit_inv_hit", int'(inv_hit), 1);
    chk("lit_inv_slot", int'(inv_slot), 1);
    inv_addr = 3'd7; #1;
    chk("lit_inv_miss", int'(inv_hit), 0);
`endif

    do_req(2'd0, 2, 6, s, st);
    chk("lit_direct_slot", s, 2);
    chk("lit_direct_status", st, 1);
    do_req(2'd0, 2, 5, s, st);
    chk("lit_direct_fail_slot", s, 0);
    chk("lit_direct_fail_status", st, 2);
    chk("lit_direct_fail_rd", int'(rd_data[5:3]), 6);
    chk("lit_direct_fail_count", int'(alloc_count), 2);

    // Remaining healthy slots 3..7 in order.
    for (int k = 3; k < 8; k++) begin
      do_req(2'd2, 0, 7 - k, s, st);
      chk("lit_healthy_slot", s, k);
      chk("lit_healthy_status", st, 0);
    end
    do_req(2'd2, 0, 1, s, st);
    chk("lit_healthy_exhausted", st, 2);
    do_req(2'd1, 0, 4, s, st);
    chk("lit_auto_deg_slot", s, 0);
    chk("lit_auto_deg_status", st, 1);
    chk("lit_full", int'(full), 1);
    chk("lit_full_count", int'(alloc_count), 8);
    do_req(2'd1, 0, 2, s, st);
    chk("lit_full_auto_fail", st, 2);
    do_req(2'd3, 0, 2, s, st);
    chk("lit_mode3_fail", st, 2);

    // Request held while mask_load pulses: not accepted that cycle.
    @(posedge clk); #1;
    req_valid = 1'b1; req_mode = 2'd2; req_src = 3'd4;
    mask_load = 1'b1; fault_mask = 8'b1000_0001;
    @(negedge clk);
    chk("lit_mask_blocks_ready", int'(req_ready), 0);
    @(posedge clk); #1;
    mask_load = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("lit_reinit_count", int'(alloc_count), 0);
    chk("lit_reinit_full", int'(full), 0);
    do_req(2'd2, 0, 4, s, st);
    chk("lit_reinit_slot", s, 1);
    chk("lit_reinit_status", st, 0);

    // Reset while in SEARCH aborts the request.
    @(posedge clk); #1;
    req_valid = 1'b1; req_mode = 2'd1; req_src = 3'd5;
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("lit_abort_rsp_valid", int'(rsp_valid), 0);
    end
    chk("lit_abort_loaded", int'(loaded), 0);
    chk("lit_abort_count", int'(alloc_count), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_mask(8'($urandom));

    // Randomised traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(posedge clk); #1;
      r = $urandom_range(0, 9);
      req_valid  = ($urandom_range(0, 2) != 0);
      req_mode   = (r < 3) ? 2'd1 : (r < 6) ? 2'd2 : (r < 9) ? 2'd0 : 2'd3;
      req_target = AW'($urandom);
      req_src    = AW'($urandom);
      mask_load  = ($urandom_range(0, 59) == 0);
      fault_mask = N'($urandom);
      rd_addr    = (P*AW)'($urandom);
`ifdef REMAP_INVERSE_EN
      inv_addr   = AW'($urandom);
`endif
    end
    @(posedge clk); #1;
    req_valid = 1'b0; mask_load = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
